hilo_div_unit: RTL

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

---
 rtl/hilo_div_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register pair with a 32-cycle restoring divider (DIV/DIVU, MTHI/MTLO, MFHI/MFLO).
//   clk, resetn (async active-low)
//   hilowrite/hilodst/wdata : MTHI/MTLO write port; hilosrc/rdata : MFHI/MFLO read port
//   div_start/div_signed/div_a/div_b : divide request; flush : cancel division
//   div_busy : high while dividing; div_done : one-cycle result pulse
module hilo_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hilowrite,
  input  logic        hilodst,
  input  logic        hilosrc,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        flush,
  output logic        div_busy,
  output logic        div_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] hi, lo, quo, dvs, rem, mag_a, mag_b, quo_nx, rem_nx, res_q, res_r;
  logic [32:0] shifted, diff;
  logic [5:0] cnt;
  logic neg_q, neg_r, accept, by_zero, finish, q_bit;
  assign accept  = state == IDLE && div_start && !flush;
  assign by_zero = accept && div_b == 32'd0;
  assign finish  = state == RUN && !flush && cnt == 6'd31;
  assign mag_a   = div_signed && div_a[31] ? -div_a : div_a;
  assign mag_b   = div_signed && div_b[31] ? -div_b : div_b;
  // 33-bit partial remainder: shift in the next dividend bit, keep the difference if it did not borrow
  assign shifted = {rem, quo[31]};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = !diff[32];
  assign rem_nx  = q_bit ? diff[31:0] : shifted[31:0];
  assign quo_nx  = {quo[30:0], q_bit};
  assign res_q   = neg_q ? -quo_nx : quo_nx;
  assign res_r   = neg_r ? -rem_nx : rem_nx;
  assign rdata    = hilosrc ? hi : lo;
  assign div_busy = state == RUN;
  assign div_done = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (accept ? (by_zero ? DONE : RUN) : IDLE) :
               state == RUN  ? (flush ? IDLE : (cnt == 6'd31 ? DONE : RUN)) : IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
      quo <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (accept) begin
        quo <= mag_a;
        dvs <= mag_b;
        rem <= '0;
        cnt <= '0;
        neg_q <= div_signed & (div_a[31] ^ div_b[31]);
        neg_r <= div_signed & div_a[31];
      end else if (state == RUN) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt + 6'd1;
      end
      // a division result overrides a same-cycle MTHI/MTLO on both registers
      if (by_zero) begin
        hi <= div_a;
        lo <= '1;
      end else if (finish) begin
        hi <= res_r;
        lo <= res_q;
      end else if (hilowrite && hilodst) hi <= wdata;
      else if (hilowrite) lo <= wdata;
    end
  end
endmodule
